// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state type and port index constants shared by the memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LDR  = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin winner; on a tie the port not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic win_o
);
    assign win_o = (req0_i && req1_i) ? !last_i : (req1_i ? PORT_LDR : PORT_CORE);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between the core and the
// program-loader port with round-robin arbitration and a per-access timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic              core_err,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic              ldr_err,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    state_e                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     last_q, last_d;
    logic [7:0]               wait_q, wait_d;
    logic [1:0]               err_q, err_d;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic                     win;
    logic                     sel_we;
    logic                     timeout;

    rr_pick2 u_pick (
        .req0_i (core_req),
        .req1_i (ldr_req),
        .last_i (last_q),
        .win_o  (win)
    );

    assign sel_we    = grant_q ? ldr_we : core_we;
    assign timeout   = wait_q == 8'(MAX_WAIT - 1);
    assign mem_en    = state_q == ACCESS;
    assign mem_we    = mem_en && sel_we;
    assign mem_addr  = grant_q ? ldr_addr : core_addr;
    assign mem_wdata = grant_q ? ldr_wdata : core_wdata;
    assign core_ack  = state_q == DONE && grant_q == PORT_CORE;
    assign ldr_ack   = state_q == DONE && grant_q == PORT_LDR;
    assign core_err  = core_ack && err_q[PORT_CORE];
    assign ldr_err   = ldr_ack && err_q[PORT_LDR];
    assign core_rdata = rdata_q[PORT_CORE];
    assign ldr_rdata  = rdata_q[PORT_LDR];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wait_d  = wait_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (core_req || ldr_req) begin
                grant_d = win;
                last_d  = win;
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // ready takes priority over a timeout landing in the same cycle
                if (mem_ready) begin
                    if (!sel_we) rdata_d[grant_q] = mem_rdata;
                    err_d[grant_q] = 1'b0;
                    state_d = DONE;
                end else if (timeout) begin
                    err_d[grant_q] = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= PORT_CORE;
            last_q  <= PORT_LDR;
            wait_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized two-requester run checked
// against a transaction-level model of arbitration order, timeout and read data.
module tb_mem_arbiter;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0, ldr_addr = '0, ldr_wdata = '0;
    logic        core_ack, core_err, ldr_ack, ldr_err;
    logic [31:0] core_rdata, ldr_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  en_cnt = '0;
    logic [7:0]  cur_dly = '0;
    logic        stray = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    int          checks = 0;
    int          errors = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_err(ldr_err), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Memory model: ready arrives cur_dly cycles into an access; stray ready outside accesses.
    assign mem_rdata = mem[mem_addr[7:0]];
    assign mem_ready = mem_en ? (en_cnt == cur_dly) : stray;

    always @(posedge clk) begin
        en_cnt <= mem_en ? en_cnt + 8'd1 : 8'd0;
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_en && mem_we && mem_ready) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d; ref_mem[a] = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic run_one(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                           input logic [7:0] dly, output int acks, output int en_n,
                           output int bus_bad, output logic err, output logic [31:0] rd);
        acks = 0; en_n = 0; bus_bad = 0; err = 1'bx; rd = 'x;
        cur_dly = dly;
        if (p) begin ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1; end
        else begin core_we = we; core_addr = a; core_wdata = d; core_req = 1'b1; end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (mem_en) begin
                en_n++;
                if (mem_we !== we || mem_addr !== a || (we && mem_wdata !== d)) bus_bad++;
            end
            if (core_ack || ldr_ack) begin
                acks++;
                err = p ? ldr_err : core_err;
                rd  = p ? ldr_rdata : core_rdata;
                if (p ? core_ack : ldr_ack) bus_bad++;
                core_req = 1'b0; ldr_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) load(8'(i), $urandom);
        tick();
        checks++;
        if ({mem_en, mem_we, core_ack, ldr_ack, core_err, ldr_err} !== 6'b0) begin
            errors++; $display("FAIL rst_ctl got %b want 000000", {mem_en, mem_we, core_ack, ldr_ack, core_err, ldr_err});
        end
        checks++;
        if (core_rdata !== 32'h0 || ldr_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_rdata got %h/%h want 0/0", core_rdata, ldr_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read;
        load(8'h10, 32'hDEADBEEF);
        cur_dly = 8'd0; stray = 1'b1;
        core_we = 1'b0; core_addr = 32'h10; core_req = 1'b1;
        tick();
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10 || core_ack !== 1'b0) begin
            errors++; $display("FAIL rd_access got en=%b we=%b addr=%h ack=%b want 1 0 10 0", mem_en, mem_we, mem_addr, core_ack);
        end
        tick();
        checks++;
        if (core_ack !== 1'b1 || ldr_ack !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL rd_ack got ack=%b/%b en=%b want 1/0 0", core_ack, ldr_ack, mem_en);
        end
        checks++;
        if (core_rdata !== 32'hDEADBEEF || core_err !== 1'b0) begin
            errors++; $display("FAIL rd_data got %h err=%b want deadbeef err=0", core_rdata, core_err);
        end
        core_req = 1'b0; stray = 1'b0;
        tick();
        checks++;
        if (core_ack !== 1'b0 || core_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_hold got ack=%b rdata=%h want 0 deadbeef", core_ack, core_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int port[4];
        int cyc[4];
        int n = 0;
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        cur_dly = 8'd0;
        core_we = 1'b0; core_addr = 32'h1; ldr_we = 1'b0; ldr_addr = 32'h2;
        core_req = 1'b1; ldr_req = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (core_ack || ldr_ack) begin port[n] = ldr_ack ? 1 : 0; cyc[n] = c; n++; end
        end
        core_req = 1'b0; ldr_req = 1'b0;
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL b2b_count got %0d acks want 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (port[i] != i % 2) begin
                    errors++; $display("FAIL b2b_order ack %0d got port %0d want %0d", i, port[i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (cyc[i] - cyc[i-1] != 3) begin
                    errors++; $display("FAIL b2b_spacing ack %0d got %0d cycles want 3", i, cyc[i] - cyc[i-1]);
                end
            end
        end
        tick(); tick(); tick();
    endtask

    task automatic test_write_wait;
        int acks, en_n, bad;
        logic err;
        logic [31:0] rd;
        run_one(1'b1, 1'b1, 32'h4, 32'h12345678, 8'd3, acks, en_n, bad, err, rd);
        checks++;
        if (en_n != 4 || bad != 0) begin
            errors++; $display("FAIL wr_bus got en_cycles=%0d bad=%0d want 4 0", en_n, bad);
        end
        checks++;
        if (acks != 1 || err !== 1'b0) begin
            errors++; $display("FAIL wr_ack got acks=%0d err=%b want 1 0", acks, err);
        end
        checks++;
        if (mem[4] !== 32'h12345678) begin
            errors++; $display("FAIL wr_mem got %h want 12345678", mem[4]);
        end
        ref_mem[4] = 32'h12345678;
    endtask

    task automatic test_timeout;
        int acks, en_n, bad;
        logic err;
        logic [31:0] rd;
        load(8'h20, 32'hCAFEF00D);
        run_one(1'b0, 1'b0, 32'h20, 32'h0, 8'd255, acks, en_n, bad, err, rd);
        checks++;
        if (acks != 1 || en_n != MAX_WAIT || bad != 0) begin
            errors++; $display("FAIL to_len got acks=%0d en_cycles=%0d bad=%0d want 1 %0d 0", acks, en_n, bad, MAX_WAIT);
        end
        checks++;
        if (err !== 1'b1 || rd !== ref_mem[1]) begin
            errors++; $display("FAIL to_err got err=%b rdata=%h want 1 %h", err, rd, ref_mem[1]);
        end
        run_one(1'b0, 1'b0, 32'h20, 32'h0, 8'(MAX_WAIT - 1), acks, en_n, bad, err, rd);
        checks++;
        if (acks != 1 || en_n != MAX_WAIT || bad != 0) begin
            errors++; $display("FAIL edge_len got acks=%0d en_cycles=%0d bad=%0d want 1 %0d 0", acks, en_n, bad, MAX_WAIT);
        end
        checks++;
        if (err !== 1'b0 || rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL edge_err got err=%b rdata=%h want 0 cafef00d", err, rd);
        end
    endtask

    task automatic test_reset_mid;
        int acks = 0;
        cur_dly = 8'd255;
        ldr_we = 1'b0; ldr_addr = 32'h30; ldr_req = 1'b1;
        tick(); tick();
        checks++;
        if (mem_en !== 1'b1) begin
            errors++; $display("FAIL rm_access got en=%b want 1", mem_en);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (mem_en !== 1'b0 || ldr_ack !== 1'b0 || core_ack !== 1'b0 || ldr_rdata !== 32'h0) begin
            errors++; $display("FAIL rm_abort got en=%b ack=%b/%b rdata=%h want 0 0/0 0", mem_en, core_ack, ldr_ack, ldr_rdata);
        end
        ldr_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (core_ack || ldr_ack || mem_en) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++; $display("FAIL rm_quiet got %0d active cycles want 0", acks);
        end
    endtask

    task automatic test_random;
        bit          pend[2];
        logic        r_we[2];
        logic [31:0] r_addr[2], r_wdata[2], exp_rd[2];
        int          r_dly[2];
        bit          busy = 0, ap = 0, last_m = 1, exp_port = 0, p, e_err;
        int          en_n = 0, e_en;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; r_we[i] = 0; r_addr[i] = 0; r_wdata[i] = 0; exp_rd[i] = 0; r_dly[i] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (mem_en) begin
                if (!busy) begin busy = 1; ap = exp_port; en_n = 0; last_m = ap; end
                en_n++;
                checks++;
                if (mem_addr !== r_addr[ap] || mem_we !== r_we[ap] || (r_we[ap] && mem_wdata !== r_wdata[ap])) begin
                    errors++; $display("FAIL rnd_bus got addr=%h we=%b wdata=%h want %h %b %h", mem_addr, mem_we, mem_wdata, r_addr[ap], r_we[ap], r_wdata[ap]);
                end
            end
            if (core_ack || ldr_ack) begin
                p = ldr_ack;
                checks++;
                if (!busy || (core_ack && ldr_ack) || p !== ap) begin
                    errors++; $display("FAIL rnd_ack_port got ack=%b/%b want port %0d", core_ack, ldr_ack, ap);
                end else begin
                    e_err = r_dly[ap] >= MAX_WAIT;
                    e_en  = e_err ? MAX_WAIT : r_dly[ap] + 1;
                    if (!e_err && !r_we[ap]) exp_rd[ap] = ref_mem[r_addr[ap][7:0]];
                    if (!e_err && r_we[ap]) ref_mem[r_addr[ap][7:0]] = r_wdata[ap];
                    checks++;
                    if ((ap ? ldr_err : core_err) !== e_err || en_n != e_en) begin
                        errors++; $display("FAIL rnd_err got err=%b en_cycles=%0d want %b %0d", ap ? ldr_err : core_err, en_n, e_err, e_en);
                    end
                    checks++;
                    if (core_rdata !== exp_rd[0] || ldr_rdata !== exp_rd[1]) begin
                        errors++; $display("FAIL rnd_rdata got %h/%h want %h/%h", core_rdata, ldr_rdata, exp_rd[0], exp_rd[1]);
                    end
                end
                busy = 0;
                pend[p] = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (cyc < 3000 && !pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    r_we[i] = 1'($urandom_range(0, 1));
                    r_addr[i] = 32'($urandom_range(0, 255));
                    r_wdata[i] = $urandom;
                    r_dly[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
                end
            end
            core_req = pend[0]; core_we = r_we[0]; core_addr = r_addr[0]; core_wdata = r_wdata[0];
            ldr_req  = pend[1]; ldr_we  = r_we[1]; ldr_addr  = r_addr[1]; ldr_wdata  = r_wdata[1];
            if (!busy) exp_port = (pend[0] && pend[1]) ? !last_m : pend[1];
            cur_dly = 8'(r_dly[exp_port]);
            stray = 1'($urandom_range(0, 1));
            if (cyc >= 3000 && !pend[0] && !pend[1] && !busy) break;
        end
        checks++;
        if (pend[0] || pend[1] || busy) begin
            errors++; $display("FAIL rnd_drain got pending=%b%b busy=%b want none", pend[0], pend[1], busy);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_write_wait();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter MAX_WAIT, default 15, maximum ACCESS cycles before timeout (range 1..255).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 core_req, ldr_req  input  1 each  request from the core memory port (port 0) and the program-loader/debug port (port 1).
REQ-007 core_we, ldr_we  input  1 each  1 = write, 0 = read.
REQ-008 core_addr, ldr_addr  input  ADDR_W each  word address.
REQ-009 core_wdata, ldr_wdata  input  DATA_W each  write data.
REQ-010 core_ack, ldr_ack  output  1 each  one-cycle completion pulse.
REQ-011 core_err, ldr_err  output  1 each  timeout flag, valid only with ack.
REQ-012 core_rdata, ldr_rdata  output  DATA_W each  registered read data, valid with ack, held until the next completion on that port.
REQ-013 mem_en, mem_we  output  1 each  memory enable and write strobe.
REQ-014 mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory address and write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid while mem_ready is high.
REQ-016 mem_ready  input  1  memory completion (variable latency, 0..N cycles).

Function
REQ-017 FSM states are IDLE, ACCESS and DONE.
REQ-018 IDLE: if any req is high, the FSM latches the winner into grant and moves to ACCESS; otherwise it stays in IDLE.
REQ-019 Arbitration is 2-way round-robin: with both req high, the port not granted last wins; with one req high, that port wins.
REQ-020 ACCESS: mem_en=1; mem_we, mem_addr and mem_wdata are muxed combinationally from the granted port.
REQ-021 ACCESS: a wait counter increments each cycle with mem_ready=0.
REQ-022 ACCESS with mem_ready=1: rdata of the granted port is latched from mem_rdata (reads only), err is cleared, and the FSM goes to DONE.
REQ-023 ACCESS timeout: mem_ready=0 with wait counter == MAX_WAIT-1 sets err for the granted port and moves to DONE; rdata is left unchanged.
REQ-024 mem_ready and the timeout in the same cycle: ready wins and err=0.
REQ-025 DONE: the granted port's ack=1 for exactly one cycle, mem_en=0, req is ignored, and the FSM returns to IDLE.
REQ-026 Outside ACCESS: mem_en=0 and mem_we=0; mem_addr and mem_wdata are don't-care.
REQ-027 Requesters hold req, we, addr and wdata stable from assertion until ack.
REQ-028 A req still high in the IDLE cycle after ack counts as a new request.
REQ-029 Latency with a zero-wait memory is 2 cycles from the edge sampling req in IDLE to ack; throughput is one access per 3 cycles.
REQ-030 The wait counter clears on every entry to ACCESS.
REQ-031 mem_ready outside ACCESS is ignored.
REQ-032 Requests are never dropped: a losing port stays pending and is granted on the next arbitration.

Reset
REQ-033 Reset puts the FSM in IDLE, sets last-grant to port 1 (so port 0 wins the first tie), clears the wait counter, and drives both ack, both err and mem_en/mem_we to 0.
REQ-034 Reset clears both rdata registers to 0.
REQ-035 Reset during ACCESS or DONE aborts the transfer: no ack is issued and write completion is not guaranteed.

Structure
REQ-036 Package mem_arb_pkg holds the state enum (IDLE, ACCESS, DONE) and the port index constants PORT_CORE=0 and PORT_LDR=1.
REQ-037 Sub-module rr_pick2 holds the combinational 2-way round-robin winner selection (inputs: two reqs and last-grant; output: winner index).
REQ-038 The FSM, wait counter and rdata registers stay in mem_arbiter.

Verification
REQ-039 Core read of addr 0x10 with mem_ready=1 immediately, mem_rdata=0xDEADBEEF -> core_ack 2 cycles after req is sampled, core_rdata=0xDEADBEEF, core_err=0.
REQ-040 core_req and ldr_req both high out of reset -> core granted first, then ldr; a repeat of both -> order core, ldr, core, ldr.
REQ-041 ldr write of addr 0x4, data 0x12345678, mem_ready delayed 3 cycles -> mem_en high for 4 cycles, mem_we=1, ldr_ack once, ldr_err=0.
REQ-042 mem_ready held 0, MAX_WAIT=15 -> ack with err=1 after 15 ACCESS cycles; rdata unchanged.
REQ-043 reset asserted in the 2nd ACCESS cycle -> next cycle IDLE, mem_en=0, no ack pulse.
REQ-044 mem_ready=1 on the timeout cycle -> err=0 and rdata updated.
